// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator running on the pixel clock. A two-flop synchroniser
// brings the PLL lock indication into the clock domain; its second flop doubles
// as the IDLE/ACTIVE state register. While ACTIVE, a horizontal/vertical counter
// pair scans the raster and a registered decode drives sync, data-enable,
// coordinates and the line/frame strobes one clock after the counter state.
// Losing lock parks the counters at (0,0) and the outputs at their idle values,
// so a relock always begins with a fresh frame_start.
// CW must be wide enough to hold both H_TOTAL-1 and V_TOTAL-1.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pll_locked,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_MAX      = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_MAX      = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    // ACTIVE exactly when the synchronised lock (second flop) is high
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    logic          r_lock_meta;
    state_t        r_state;
    state_t        w_state_next;

    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;
    logic [CW-1:0] w_h_next;
    logic [CW-1:0] w_v_next;

    logic          r_hsync;
    logic          r_vsync;
    logic          r_de;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_line_start;
    logic          r_frame_start;

    logic          w_hsync_next;
    logic          w_vsync_next;
    logic          w_de_next;
    logic [CW-1:0] w_x_next;
    logic [CW-1:0] w_y_next;
    logic          w_line_start_next;
    logic          w_frame_start_next;

    // Lock synchroniser: first flop catches the asynchronous input, second is the state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_meta <= 1'b0;
            r_state     <= ST_IDLE;
        end else begin
            r_lock_meta <= pll_locked;
            r_state     <= w_state_next;
        end
    end

    // Next state follows the first synchroniser flop
    always_comb begin
        w_state_next = ST_IDLE;
        if (r_lock_meta) begin
            w_state_next = ST_ACTIVE;
        end
    end

    // Counter advance and registered-output decode; idle values are the defaults
    always_comb begin
        w_h_next           = '0;
        w_v_next           = '0;
        w_hsync_next       = 1'b1;
        w_vsync_next       = 1'b1;
        w_de_next          = 1'b0;
        w_x_next           = '0;
        w_y_next           = '0;
        w_line_start_next  = 1'b0;
        w_frame_start_next = 1'b0;

        case (r_state)
            ST_ACTIVE: begin
                if (r_h_cnt == H_MAX) begin
                    w_h_next = '0;
                    w_v_next = (r_v_cnt == V_MAX) ? '0 : (r_v_cnt + CW'(1));
                end else begin
                    w_h_next = r_h_cnt + CW'(1);
                    w_v_next = r_v_cnt;
                end

                w_de_next          = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
                w_hsync_next       = !((r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END));
                w_vsync_next       = !((r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END));
                w_x_next           = r_h_cnt;
                w_y_next           = r_v_cnt;
                w_line_start_next  = (r_h_cnt == '0);
                w_frame_start_next = (r_h_cnt == '0) && (r_v_cnt == '0);
            end
            default: begin
                // IDLE: counters held at origin, outputs idle (defaults above)
            end
        endcase
    end

    // Raster counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_next;
            r_v_cnt <= w_v_next;
        end
    end

    // Output registers, all aligned one clock behind the counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_hsync_next;
            r_vsync       <= w_vsync_next;
            r_de          <= w_de_next;
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_line_start  <= w_line_start_next;
            r_frame_start <= w_frame_start_next;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen on a reduced raster (60 x 40) so whole frames
// fit in a short run. The reference model treats the raster as a position
// counter: after lock has been seen at two successive edges, output cycle n of
// the scan shows pixel (n mod H_TOTAL, n div H_TOTAL mod V_TOTAL), with every
// decoded field computed from the porch/sync arithmetic.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int HA = 40, HF = 4, HS = 8, HB = 8;
    localparam int VA = 30, VF = 3, VS = 2, VB = 5;
    localparam int CW = 10;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int BW = 2 * CW + 5;
    localparam logic [BW-1:0] IDLE_V = {2'b11, {(BW-2){1'b0}}};

    logic          clk;
    logic          reset_n;
    logic          pll_locked;
    logic          hsync, vsync, de, line_start, frame_start;
    logic [CW-1:0] x, y;
    logic [BW-1:0] obs;

    int n_cmp = 0;
    int n_err = 0;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CW(CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .x          (x),
        .y          (y),
        .line_start (line_start),
        .frame_start(frame_start)
    );

    assign obs = {hsync, vsync, de, line_start, frame_start, x, y};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output bundle for scan position p (output cycles since scan start)
    function automatic logic [BW-1:0] ref_at(input int p);
        int q, xx, yy;
        logic hs, vs, d;
        q  = p % FRAME;
        xx = q % HT;
        yy = q / HT;
        d  = (xx < HA) && (yy < VA);
        hs = !((xx >= HA + HF) && (xx < HA + HF + HS));
        vs = !((yy >= VA + VF) && (yy < VA + VF + VS));
        return {hs, vs, d, (xx == 0), (q == 0), CW'(xx), CW'(yy)};
    endfunction

    // Reference model: lock seen two edges ago means the scan is running
    logic          m_s1, m_s2;
    int            m_pos;
    logic [BW-1:0] exp_obs;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1    <= 1'b0;
            m_s2    <= 1'b0;
            m_pos   <= 0;
            exp_obs <= IDLE_V;
        end else begin
            m_s1 <= pll_locked;
            m_s2 <= m_s1;
            if (m_s2) begin
                exp_obs <= ref_at(m_pos);
                m_pos   <= m_pos + 1;
            end else begin
                exp_obs <= IDLE_V;
                m_pos   <= 0;
            end
        end
    end

    task automatic test_reset();
        reset_n    = 1'b0;
        pll_locked = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs !== IDLE_V) begin
            n_err++;
            $display("FAIL reset_idle: got %h expected %h", obs, IDLE_V);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== ((i < 2) ? IDLE_V : ref_at(0))) begin
                n_err++;
                $display("FAIL reset_release_edge%0d: got %h expected %h", i + 1, obs,
                         (i < 2) ? IDLE_V : ref_at(0));
            end
        end
        $display("test_reset done: frame_start=%0d x=%0d y=%0d", frame_start, x, y);
    endtask

    task automatic test_one_line();
        int found = 0;
        int de_n = 0, hs_n = 0, ls_n = 0;
        logic [CW-1:0] hs_first = '0, x_max = '0, y0;
        for (int c = 0; c < FRAME + HT; c++) begin
            @(negedge clk);
            if (line_start && (y < CW'(VA))) begin
                found = 1;
                break;
            end
        end
        n_cmp++;
        if (found == 0) begin
            n_err++;
            $display("FAIL line_wait: got no line_start expected one within %0d clk", FRAME + HT);
            return;
        end
        y0 = y;
        for (int c = 0; c < HT; c++) begin
            n_cmp++;
            if (obs !== exp_obs) begin
                n_err++;
                $display("FAIL line_model c=%0d: got %h expected %h", c, obs, exp_obs);
            end
            if (de) de_n++;
            if (!hsync) begin
                if (hs_n == 0) hs_first = x;
                hs_n++;
            end
            if (line_start) ls_n++;
            if (x > x_max) x_max = x;
            @(negedge clk);
        end
        n_cmp++;
        if (de_n != HA) begin
            n_err++;
            $display("FAIL line_de_count: got %0d expected %0d", de_n, HA);
        end
        n_cmp++;
        if (hs_n != HS || hs_first != CW'(HA + HF)) begin
            n_err++;
            $display("FAIL line_hsync: got %0d clk from x=%0d expected %0d from x=%0d",
                     hs_n, hs_first, HS, HA + HF);
        end
        n_cmp++;
        if (ls_n != 1) begin
            n_err++;
            $display("FAIL line_start_count: got %0d expected 1", ls_n);
        end
        n_cmp++;
        if (x_max != CW'(HT - 1) || x != '0 || y != CW'((int'(y0) + 1) % VT)) begin
            n_err++;
            $display("FAIL line_wrap: got xmax=%0d x=%0d y=%0d expected xmax=%0d x=0 y=%0d",
                     x_max, x, y, HT - 1, (int'(y0) + 1) % VT);
        end
        $display("test_one_line done: y=%0d de=%0d hsync_low=%0d", y0, de_n, hs_n);
    endtask

    task automatic test_two_frames();
        int found = 0;
        int fs_n = 0, fs_first = -1, fs_second = -1;
        int vs_n = 0, de_blank = 0, de_total = 0;
        logic [CW-1:0] vs_fx = '0, vs_fy = '0, vs_lx = '0, vs_ly = '0;
        for (int c = 0; c < FRAME + 10; c++) begin
            @(negedge clk);
            if (frame_start) begin
                found = 1;
                break;
            end
        end
        n_cmp++;
        if (found == 0) begin
            n_err++;
            $display("FAIL frame_wait: got no frame_start expected one within %0d clk", FRAME + 10);
            return;
        end
        for (int c = 0; c < 2 * FRAME; c++) begin
            n_cmp++;
            if (obs !== exp_obs) begin
                n_err++;
                $display("FAIL frame_model c=%0d: got %h expected %h", c, obs, exp_obs);
            end
            if (frame_start) begin
                if (fs_n == 0) fs_first = c;
                else if (fs_n == 1) fs_second = c;
                fs_n++;
            end
            if (!vsync) begin
                if (vs_n == 0) begin
                    vs_fx = x;
                    vs_fy = y;
                end
                vs_lx = x;
                vs_ly = y;
                vs_n++;
            end
            if (de) de_total++;
            if (de && (y >= CW'(VA))) de_blank++;
            @(negedge clk);
        end
        n_cmp++;
        if (fs_n != 2 || (fs_second - fs_first) != FRAME || frame_start !== 1'b1) begin
            n_err++;
            $display("FAIL frame_period: got %0d pulses spacing %0d expected 2 spacing %0d",
                     fs_n, fs_second - fs_first, FRAME);
        end
        n_cmp++;
        if (vs_n != 2 * VS * HT) begin
            n_err++;
            $display("FAIL vsync_len: got %0d expected %0d", vs_n, 2 * VS * HT);
        end
        n_cmp++;
        if (vs_fx != '0 || vs_fy != CW'(VA + VF) || vs_lx != CW'(HT - 1) ||
            vs_ly != CW'(VA + VF + VS - 1)) begin
            n_err++;
            $display("FAIL vsync_span: got (%0d,%0d)..(%0d,%0d) expected (0,%0d)..(%0d,%0d)",
                     vs_fx, vs_fy, vs_lx, vs_ly, VA + VF, HT - 1, VA + VF + VS - 1);
        end
        n_cmp++;
        if (de_blank != 0 || de_total != 2 * HA * VA) begin
            n_err++;
            $display("FAIL frame_de: got blank=%0d total=%0d expected 0 and %0d",
                     de_blank, de_total, 2 * HA * VA);
        end
        $display("test_two_frames done: period=%0d vsync_low=%0d de=%0d",
                 fs_second - fs_first, vs_n, de_total);
    endtask

    task automatic test_lock_drop();
        int found = 0;
        int hold = $urandom_range(2, 10);
        logic [CW-1:0] tx = CW'($urandom_range(1, HT - 1));
        logic [CW-1:0] ty = CW'($urandom_range(1, VT - 1));
        for (int c = 0; c < FRAME + 10; c++) begin
            @(negedge clk);
            if (x == tx && y == ty) begin
                found = 1;
                break;
            end
        end
        n_cmp++;
        if (found == 0) begin
            n_err++;
            $display("FAIL drop_wait: got no (%0d,%0d) expected it within a frame", tx, ty);
            return;
        end
        pll_locked = 1'b0;
        // E0 captures the drop, E1 clears run, E2 loads idle outputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_obs || (i == 2 && obs !== IDLE_V)) begin
                n_err++;
                $display("FAIL drop_edge%0d: got %h expected %h", i, obs, exp_obs);
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== IDLE_V) begin
                n_err++;
                $display("FAIL drop_hold%0d: got %h expected %h", i, obs, IDLE_V);
            end
        end
        pll_locked = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== ((i < 2) ? IDLE_V : ref_at(0))) begin
                n_err++;
                $display("FAIL relock_edge%0d: got %h expected %h", i + 1, obs,
                         (i < 2) ? IDLE_V : ref_at(0));
            end
        end
        $display("test_lock_drop done: dropped at (%0d,%0d) held %0d clk", tx, ty, hold);
    endtask

    task automatic test_async_reset();
        int found = 0;
        logic [CW-1:0] tx = CW'($urandom_range(1, HT - 1));
        logic [CW-1:0] ty = CW'($urandom_range(1, VT - 1));
        for (int c = 0; c < FRAME + 10; c++) begin
            @(negedge clk);
            if (x == tx && y == ty) begin
                found = 1;
                break;
            end
        end
        n_cmp++;
        if (found == 0) begin
            n_err++;
            $display("FAIL areset_wait: got no (%0d,%0d) expected it within a frame", tx, ty);
            return;
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== IDLE_V) begin
            n_err++;
            $display("FAIL areset_immediate: got %h expected %h", obs, IDLE_V);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== ((i < 2) ? IDLE_V : ref_at(0))) begin
                n_err++;
                $display("FAIL areset_release_edge%0d: got %h expected %h", i + 1, obs,
                         (i < 2) ? IDLE_V : ref_at(0));
            end
        end
        $display("test_async_reset done: reset at (%0d,%0d)", tx, ty);
    endtask

    task automatic test_glitch();
        for (int it = 0; it < 8; it++) begin
            int gap = $urandom_range(5, 3 * HT);
            int captured = $urandom_range(0, 1);
            int idle_n = 0, fs_n = 0, range_bad = 0;
            repeat (gap) @(negedge clk);
            if (captured != 0) begin
                pll_locked = 1'b0;
                @(negedge clk);
                pll_locked = 1'b1;
            end else begin
                @(posedge clk);
                #(1 + $urandom_range(0, 3)) pll_locked = 1'b0;
                #(1 + $urandom_range(0, 3)) pll_locked = 1'b1;
            end
            for (int c = 0; c < 2 * HT; c++) begin
                @(negedge clk);
                n_cmp++;
                if (obs !== exp_obs) begin
                    n_err++;
                    $display("FAIL glitch_model it=%0d c=%0d: got %h expected %h", it, c, obs, exp_obs);
                end
                if (c < 8) begin
                    if (obs === IDLE_V) idle_n++;
                    if (frame_start) fs_n++;
                end
                if (x >= CW'(HT) || y >= CW'(VT)) range_bad++;
            end
            n_cmp++;
            if (idle_n != captured || (captured != 0 && fs_n != 1) || range_bad != 0) begin
                n_err++;
                $display("FAIL glitch_effect it=%0d: got idle=%0d fs=%0d bad=%0d expected idle=%0d fs=%0d bad=0",
                         it, idle_n, fs_n, range_bad, captured, captured);
            end
            $display("test_glitch it=%0d captured=%0d idle=%0d", it, captured, idle_n);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        test_reset();
        test_one_line();
        test_two_frames();
        test_lock_drop();
        test_async_reset();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Run-time bound so a stuck DUT cannot hang the simulation
    initial begin
        #5ms;
        $display("FAIL watchdog: got no completion expected finish within 5 ms");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the VGA output path, clocked directly by the 25 MHz pixel clock from the system PLL. It produces horizontal and vertical sync, data-enable, and the current pixel coordinates for the downstream pixel source and DAC. It also produces line-start and frame-start strobes. The generator stays idle until the PLL lock indication has been synchronised into its domain, and it restarts cleanly whenever lock is lost.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CW, 10, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock (PLL outclk_0, 25 MHz)
- reset_n  in  1  asynchronous, active-low reset
- pll_locked  in  1  PLL locked, asynchronous to clk
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- de  out  1  data enable, high during visible area
- x  out  CW  horizontal position of the current output cycle
- y  out  CW  vertical position of the current output cycle
- line_start  out  1  one-cycle pulse when x==0
- frame_start  out  1  one-cycle pulse when x==0 and y==0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Lock synchroniser: two flops, both cleared by reset_n. `run` = second flop.
- Counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1), both cleared by reset_n.
  - run=0: both forced to 0 every cycle.
  - run=1: h_cnt increments each cycle. At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 when both counters are at their maxima.
- Decode from (h_cnt, v_cnt), registered into outputs:
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hsync = 0 iff H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. [656,752)
  - vsync = 0 iff V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. [490,492), for whole lines
  - x = h_cnt, y = v_cnt, always driven, including blanking
  - line_start = (h_cnt==0); frame_start = (h_cnt==0 && v_cnt==0)
- While run=0, output registers load the idle state instead of the decode.
- Two states, IDLE (run=0) and ACTIVE (run=1). No other control state.
- Lock loss mid-frame: on the first cycle run is sampled 0, counters go to 0 and outputs go idle. The partial frame is abandoned and no strobe fires. On relock, scan restarts at (0,0) with a fresh frame_start.
- reset_n assertion at any time: all registers are cleared immediately (asynchronously) to their reset values.

## Timing
- Reset/idle output values: hsync=1, vsync=1, de=0, x=0, y=0, line_start=0, frame_start=0.
- Lock latency:
  - pll_locked rises before edge E0, so run=1 after edge E1.
  - Counter is (0,0) during the cycle after E1.
  - Outputs show x=0, y=0, de=1, frame_start=1 after edge E2.
- Output latency: exactly 1 clk from counter state to outputs. All outputs are mutually aligned, with no combinational paths from inputs to outputs.
- Frame period: 420000 clk. Line period: 800 clk.
- de high for 640 clk per visible line and 307200 clk per frame.
- Simultaneous events:
  - h wrap and v wrap in the same cycle yields one frame_start with line_start also high.
  - pll_locked dropping on the wrap cycle: the idle state wins once run=0.

## Test plan
- Reset with pll_locked=1, release reset_n → outputs hold idle values for exactly 2 edges, then x=0, y=0, de=1, frame_start=1 on the third.
- Free run, one line → de high for output cycles x=0..639. hsync low for x=656..751 (96 cycles). line_start high only at x=0. x reaches 799 and wraps to 0 with y incremented.
- Free run, two frames → 420000 clk between frame_start pulses. vsync low for exactly 1600 clk, from (x=0,y=490) through (x=799,y=491). de never high for y≥480.
- Drop pll_locked at (x=300,y=200) → 2 clk later outputs idle (hsync=1, vsync=1, de=0, x=y=0). Reassert → restart at (0,0) with frame_start after 2 clk sync + 1 output clk.
- Assert reset_n low mid-line (x=700,y=100) → all outputs at reset values in the same cycle, without waiting for a clock edge. Release → identical behaviour to the first scenario.
- Apply a pll_locked glitch of 1 clk width → frame is abandoned only if the glitch is captured by the synchroniser. Either way the counters are consistent: no x≥800 and no y≥525.
